seq_mult_param: RTL and testbench
=================================

Name: seq_mult_param

Overview:
Parametrised sequential shift-add multiplier, the successor to the fixed 16-bit unit. It computes one multiplier bit per clock, so each product takes WIDTH+1 cycles. It adds run-time signed/unsigned selection, a busy/done handshake, abort, and a result register that holds until the next product completes. It sits beside the datapath as a low-area arithmetic unit for control FSMs that can tolerate multi-cycle latency.

Parameters:
WIDTH, 16, operand width in bits (legal range 2..32); the result is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request a new product; sampled only while idle (busy=0)
signed_mode  input  1  sampled with start; 1 = two's-complement operands, 0 = unsigned
ain  input  WIDTH  multiplicand, sampled with start
bin  input  WIDTH  multiplier, sampled with start
abort  input  1  synchronous cancel of an operation in progress
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse when yout has been updated
yout  output  2*WIDTH  product; holds its value between operations

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-operation): state=IDLE, busy=0, done=0, yout=0, all internal registers=0. Operation resumes on the first clk edge after rst falls.
- States: IDLE -> CALC -> FIN -> IDLE.
- IDLE: when start=1 at edge E0, the block:
  - latches signed_mode;
  - latches |ain| and |bin| as WIDTH-bit magnitudes (signed mode takes the two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1));
  - latches neg = signed_mode & (ain[MSB] ^ bin[MSB]);
  - clears the accumulator and bit counter;
  - goes to CALC with busy=1 after E0.
- CALC: each edge consumes one multiplier bit, LSB first. If the bit is 1, the multiplicand is added into the accumulator's upper part; the accumulator then shifts right one place. The upper part is WIDTH+1 bits wide, so carry-out is kept. After exactly WIDTH CALC edges (E1..EWIDTH) the state goes to FIN.
- FIN (edge E(WIDTH+1)):
  - yout <= neg ? -acc : acc (2*WIDTH-bit two's complement);
  - done=1 for that one cycle;
  - busy=0;
  - state goes to IDLE.
- Latency: done is high in the cycle after edge E(WIDTH+1), i.e. 17 edges after start for WIDTH=16. Throughput is one product per WIDTH+2 cycles when start is held high; start may stay high, and a new operation is accepted on the edge where busy=0.
- start while busy=1 is ignored. Operands and signed_mode may change freely after acceptance.
- abort=1 while in CALC or FIN: the next edge returns to IDLE with busy=0 and done=0, and yout is unchanged. abort in IDLE has no effect. If abort and start are both 1 in IDLE, start wins (abort is a no-op there).
- Unsigned range: full 2*WIDTH-bit result, no overflow possible.
- Signed range: the result is always representable in 2*WIDTH bits, including (-2^(WIDTH-1))^2.
- The * operator and any combinational WIDTH x WIDTH multiplier are forbidden. Exactly one adder of width WIDTH+1 is allowed.
- yout never shows partial accumulation; it changes only at FIN or reset.

Test Plan:
- WIDTH=16, unsigned, ain=0xFFFF, bin=0xFFFF, start pulse -> busy high for 17 cycles; done pulses once 17 edges after start; yout=0xFFFE0001.
- WIDTH=16, signed: 3 x -5 (0x0003, 0xFFFB) -> yout=0xFFFFFFF1. -32768 x -32768 -> yout=0x40000000. -1 x -1 -> yout=0x00000001. 0 x 0x8000 -> yout=0x00000000 (no negative zero).
- start held high with new operands each cycle, first 0x0002 x 0x0003 then 0x0004 x 0x0005 -> the second start is ignored while busy; back-to-back results are 6 then 20; exactly one done per product.
- abort asserted on the 5th CALC cycle after a prior result 0x00000006 -> busy drops on the next edge, no done pulse, yout stays 0x00000006; the next start completes normally.
- rst pulsed mid-CALC -> busy=0, done=0, yout=0 immediately (asynchronously); after release, a 7 x 9 request yields yout=0x0000003F.
- WIDTH=4 and WIDTH=32 instances: exhaustive (WIDTH=4) and random (WIDTH=32) signed and unsigned products match a reference model; latency is WIDTH+1 in every case.

Source files
------------

// File: rtl/seq_mult_param_if.sv
// Request/response bundle for the sequential multiplier.
// The master side issues operands and controls; the slave side is the multiplier.
interface seq_mult_param_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       ain;
    logic [WIDTH-1:0]       bin;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     yout;

    modport master (
        output start, signed_mode, ain, bin, abort,
        input  busy, done, yout
    );

    modport slave (
        input  start, signed_mode, ain, bin, abort,
        output busy, done, yout
    );
endinterface

// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier: one multiplier bit per clock, WIDTH+1
// cycles per product. Signed operands are reduced to magnitudes on entry and
// the sign is reapplied when the result is written.
module seq_mult_param #(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    seq_mult_param_if.slave   bus
);
    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   sm_q, sm_d;
    logic                   sgn_q, sgn_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH:0]       acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [2*WIDTH-1:0]     yout_q, yout_d;

    logic [WIDTH:0]         addend;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     prod;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sm_q     <= 1'b0;
            sgn_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            yout_q   <= '0;
        end else begin
            state_q  <= state_d;
            sm_q     <= sm_d;
            sgn_q    <= sgn_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            yout_q   <= yout_d;
        end
    end

    // Next-state logic: accept, shift-add one bit per CALC cycle, then publish.
    always_comb begin
        state_d  = state_q;
        sm_d     = sm_q;
        sgn_d    = sgn_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        yout_d   = yout_q;

        // The single WIDTH+1 adder: upper accumulator plus gated multiplicand.
        addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum    = acc_q[2*WIDTH:WIDTH] + addend;
        prod   = acc_q[2*WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sm_d     = bus.signed_mode;
                    sgn_d    = bus.ain[WIDTH-1] ^ bus.bin[WIDTH-1];
                    mcand_d  = (bus.signed_mode && bus.ain[WIDTH-1]) ? (~bus.ain + 1'b1) : bus.ain;
                    mplier_d = (bus.signed_mode && bus.bin[WIDTH-1]) ? (~bus.bin + 1'b1) : bus.bin;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = {1'b0, sum, acc_q[WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!bus.abort) begin
                    yout_d = (sm_q && sgn_q) ? (~prod + 1'b1) : prod;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drive the handshake outputs from registered state.
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = done_q;
        bus.yout = yout_q;
    end
endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param at WIDTH=16, plus exhaustive WIDTH=4 and
// randomised WIDTH=32 instances checked against a behavioural product.
module tb_seq_mult_param;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_mult_param_if #(.WIDTH(16)) b16();
    seq_mult_param_if #(.WIDTH(4))  b4();
    seq_mult_param_if #(.WIDTH(32)) b32();

    seq_mult_param #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
    seq_mult_param #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
    seq_mult_param #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // One WIDTH=16 product; returns result, edges from accept to done, busy cycles.
    task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                        input logic ab, output logic [31:0] y, output int lat, output int bc);
        b16.start = 1'b1; b16.signed_mode = sm; b16.ain = a; b16.bin = b; b16.abort = ab;
        @(posedge clk); #1;
        b16.start = 1'b0; b16.abort = 1'b0;
        lat = 0; bc = b16.busy ? 1 : 0;
        while (!b16.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (b16.busy) bc++;
        end
        y = b16.yout;
    endtask

    task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] y, output int lat);
        b4.start = 1'b1; b4.signed_mode = sm; b4.ain = a; b4.bin = b;
        @(posedge clk); #1;
        b4.start = 1'b0;
        lat = 0;
        while (!b4.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        y = b4.yout;
    endtask

    task automatic op32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] y, output int lat);
        b32.start = 1'b1; b32.signed_mode = sm; b32.ain = a; b32.bin = b;
        @(posedge clk); #1;
        b32.start = 1'b0;
        lat = 0;
        while (!b32.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        y = b32.yout;
    endtask

    initial begin
        logic [31:0] y16;
        logic [7:0]  y4;
        logic [63:0] y64;
        logic [31:0] ys [2];
        int          es [2];
        int          lat, bc, ndone;
        logic [3:0]  av, bv;
        int          ea, eb, ep;
        logic [31:0] a32, b32v;
        logic        s32;
        longint      la, lb, lp;

        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        b16.start = 0; b16.signed_mode = 0; b16.ain = '0; b16.bin = '0; b16.abort = 0;
        b4.start  = 0; b4.signed_mode  = 0; b4.ain  = '0; b4.bin  = '0; b4.abort  = 0;
        b32.start = 0; b32.signed_mode = 0; b32.ain = '0; b32.bin = '0; b32.abort = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", {63'b0, b16.busy}, 64'd0);
        check("rst done", {63'b0, b16.done}, 64'd0);
        check("rst yout", {32'b0, b16.yout}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned full-scale product, latency and busy width.
        op16(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, y16, lat, bc);
        check("u ffff*ffff", {32'b0, y16}, 64'hFFFE0001);
        check("u lat", lat, 17);
        check("u busy cycles", bc, 17);
        @(posedge clk); #1;
        check("done one cycle", {63'b0, b16.done}, 64'd0);
        check("yout holds", {32'b0, b16.yout}, 64'hFFFE0001);

        // Signed cases.
        op16(1'b1, 16'h0003, 16'hFFFB, 1'b0, y16, lat, bc);
        check("s 3*-5", {32'b0, y16}, 64'hFFFFFFF1);
        op16(1'b1, 16'h8000, 16'h8000, 1'b0, y16, lat, bc);
        check("s min*min", {32'b0, y16}, 64'h40000000);
        op16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, y16, lat, bc);
        check("s -1*-1 start beats abort", {32'b0, y16}, 64'h00000001);
        check("s lat", lat, 17);
        op16(1'b1, 16'h0000, 16'h8000, 1'b0, y16, lat, bc);
        check("s 0*min", {32'b0, y16}, 64'h00000000);

        // Start held high: second request ignored while busy, back-to-back results.
        b16.start = 1'b1; b16.signed_mode = 1'b0; b16.ain = 16'h0002; b16.bin = 16'h0003;
        @(posedge clk); #1;
        b16.ain = 16'h0004; b16.bin = 16'h0005;
        ndone = 0; ys[0] = '0; ys[1] = '0; es[0] = 0; es[1] = 0;
        for (int e = 1; e <= 35; e++) begin
            @(posedge clk); #1;
            if (b16.done) begin
                if (ndone < 2) begin
                    ys[ndone] = b16.yout;
                    es[ndone] = e;
                end
                ndone++;
            end
        end
        b16.start = 1'b0;
        check("held ndone", ndone, 2);
        check("held y0", {32'b0, ys[0]}, 64'd6);
        check("held y1", {32'b0, ys[1]}, 64'd20);
        check("held e0", es[0], 17);
        check("held e1", es[1], 35);
        @(posedge clk); #1;

        // Abort on the 5th CALC cycle.
        op16(1'b0, 16'h0002, 16'h0003, 1'b0, y16, lat, bc);
        check("pre-abort", {32'b0, y16}, 64'd6);
        b16.start = 1'b1; b16.ain = 16'h1234; b16.bin = 16'h5678;
        @(posedge clk); #1;
        b16.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("abort pre busy", {63'b0, b16.busy}, 64'd1);
        b16.abort = 1'b1;
        @(posedge clk); #1;
        b16.abort = 1'b0;
        check("abort busy", {63'b0, b16.busy}, 64'd0);
        check("abort done", {63'b0, b16.done}, 64'd0);
        check("abort yout", {32'b0, b16.yout}, 64'd6);
        ndone = 0;
        repeat (20) begin @(posedge clk); #1; if (b16.done) ndone++; end
        check("abort no done", ndone, 0);
        op16(1'b0, 16'h0011, 16'h0011, 1'b0, y16, lat, bc);
        check("post-abort", {32'b0, y16}, 64'h121);
        check("post-abort lat", lat, 17);

        // Asynchronous reset mid-CALC.
        b16.start = 1'b1; b16.ain = 16'h1234; b16.bin = 16'h0010;
        @(posedge clk); #1;
        b16.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("arst busy", {63'b0, b16.busy}, 64'd0);
        check("arst done", {63'b0, b16.done}, 64'd0);
        check("arst yout", {32'b0, b16.yout}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        op16(1'b0, 16'd7, 16'd9, 1'b0, y16, lat, bc);
        check("7*9 after rst", {32'b0, y16}, 64'h3F);

        // WIDTH=4 exhaustive, both modes.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    av = a[3:0]; bv = b[3:0];
                    ea = (s == 1) ? int'($signed(av)) : int'(av);
                    eb = (s == 1) ? int'($signed(bv)) : int'(bv);
                    ep = ea * eb;
                    op4(s[0], av, bv, y4, lat);
                    check("w4 prod", {56'b0, y4}, {56'b0, ep[7:0]});
                    check("w4 lat", lat, 5);
                end
            end
        end

        // WIDTH=32 corners then random.
        for (int i = 0; i < 30; i++) begin
            if (i == 0) begin
                a32 = 32'h80000000; b32v = 32'h80000000; s32 = 1'b1;
            end else if (i == 1) begin
                a32 = 32'hFFFFFFFF; b32v = 32'hFFFFFFFF; s32 = 1'b0;
            end else begin
                a32 = $urandom; b32v = $urandom; s32 = i[0];
            end
            la = s32 ? longint'($signed(a32)) : longint'({32'b0, a32});
            lb = s32 ? longint'($signed(b32v)) : longint'({32'b0, b32v});
            lp = la * lb;
            op32(s32, a32, b32v, y64, lat);
            check("w32 prod", y64, lp);
            check("w32 lat", lat, 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
